// File: rtl/debug_scan_slave.sv
// debug_scan_slave: virtual-JTAG scan endpoint oversampled in the clk domain.
// Captures per-channel words, shifts LSB-first, hands updates over valid/ready.
module debug_scan_slave #(
    parameter int DR_WIDTH    = 38,
    parameter int IR_WIDTH    = 2,
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         tck,
    input  logic                         tdi,
    output logic                         tdo,
    input  logic                         vs_cdr,
    input  logic                         vs_sdr,
    input  logic                         vs_udr,
    input  logic                         vs_uir,
    input  logic                         jtag_state_rti,
    input  logic [IR_WIDTH-1:0]          ir_in,
    output logic [IR_WIDTH-1:0]          ir_out,
    input  logic [NUM_CH*DR_WIDTH-1:0]   cap_data,
    output logic [DR_WIDTH-1:0]          jdo,
    output logic                         upd_valid,
    output logic [IR_WIDTH-1:0]          upd_ch,
    input  logic                         upd_ready,
    output logic                         ir_upd_pulse,
    output logic                         st_ready_test_idle,
    output logic                         overrun,
    input  logic                         overrun_clr
);

    // All JTAG-side inputs share one delay line so they stay aligned.
    localparam int SW = IR_WIDTH + 7;
    localparam logic [IR_WIDTH:0] NCH = NUM_CH[IR_WIDTH:0];

    logic [SW-1:0]       r_sync [SYNC_STAGES];
    logic                r_tck_prev;
    logic [DR_WIDTH-1:0] r_sr;
    logic [DR_WIDTH-1:0] r_jdo;
    logic                r_upd_valid;
    logic [IR_WIDTH-1:0] r_upd_ch;
    logic                r_overrun;
    logic [IR_WIDTH-1:0] r_ir_out;
    logic                r_ir_upd_pulse;

    logic [SW-1:0]       w_sync_in;
    logic [SW-1:0]       w_sync_out;
    logic                w_tck_s;
    logic                w_tdi_s;
    logic                w_cdr_s;
    logic                w_sdr_s;
    logic                w_udr_s;
    logic                w_uir_s;
    logic                w_rti_s;
    logic [IR_WIDTH-1:0] w_ir_s;
    logic                w_tck_rise;
    logic                w_in_range;
    logic [DR_WIDTH-1:0] w_cap;
    logic                w_do_cdr;
    logic                w_do_sdr;
    logic                w_do_udr;
    logic                w_do_uir;
    logic                w_accept;
    logic                w_drop;

    assign w_sync_in = {ir_in, jtag_state_rti, vs_uir, vs_udr,
                        vs_sdr, vs_cdr, tdi, tck};
    assign w_sync_out = r_sync[SYNC_STAGES-1];

    assign w_tck_s = w_sync_out[0];
    assign w_tdi_s = w_sync_out[1];
    assign w_cdr_s = w_sync_out[2];
    assign w_sdr_s = w_sync_out[3];
    assign w_udr_s = w_sync_out[4];
    assign w_uir_s = w_sync_out[5];
    assign w_rti_s = w_sync_out[6];
    assign w_ir_s  = w_sync_out[SW-1:7];

    // Synchroniser chain plus the previous tck sample for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_tck_prev <= 1'b0;
        end else begin
            r_sync[0] <= w_sync_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_tck_prev <= w_tck_s;
        end
    end

    assign w_tck_rise = w_tck_s & ~r_tck_prev;
    assign w_in_range = ({1'b0, w_ir_s} < NCH);

    // Capture-word mux; unmapped instructions read as zero.
    always_comb begin
        w_cap = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_ir_s == IR_WIDTH'(k)) begin
                w_cap = cap_data[k*DR_WIDTH +: DR_WIDTH];
            end
        end
    end

    // One action per tck edge, priority cdr > sdr > udr > uir.
    assign w_do_cdr = w_tck_rise & w_cdr_s;
    assign w_do_sdr = w_tck_rise & ~w_cdr_s & w_sdr_s;
    assign w_do_udr = w_tck_rise & ~w_cdr_s & ~w_sdr_s & w_udr_s;
    assign w_do_uir = w_tck_rise & ~w_cdr_s & ~w_sdr_s
                    & ~w_udr_s & w_uir_s;

    assign w_accept = w_do_udr & w_in_range
                    & (~r_upd_valid | upd_ready);
    assign w_drop   = w_do_udr & w_in_range
                    & r_upd_valid & ~upd_ready;

    // Scan register: capture or LSB-first shift, otherwise hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sr <= '0;
        end else if (w_do_cdr) begin
            r_sr <= w_cap;
        end else if (w_do_sdr) begin
            r_sr <= {w_tdi_s, r_sr[DR_WIDTH-1:1]};
        end
    end

    // Update word hand-off; jdo only moves when a word is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_jdo       <= '0;
            r_upd_ch    <= '0;
            r_upd_valid <= 1'b0;
        end else if (w_accept) begin
            r_jdo       <= r_sr;
            r_upd_ch    <= w_ir_s;
            r_upd_valid <= 1'b1;
        end else if (upd_ready) begin
            r_upd_valid <= 1'b0;
        end
    end

    // Sticky overrun; a new drop beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (overrun_clr) begin
            r_overrun <= 1'b0;
        end
    end

    // Registered status word and update-IR pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ir_out       <= '0;
            r_ir_upd_pulse <= 1'b0;
        end else begin
            r_ir_out       <= '0;
            r_ir_out[1:0]  <= {r_overrun, r_upd_valid};
            r_ir_upd_pulse <= w_do_uir;
        end
    end

    assign tdo                = r_sr[0];
    assign jdo                = r_jdo;
    assign upd_valid          = r_upd_valid;
    assign upd_ch             = r_upd_ch;
    assign overrun            = r_overrun;
    assign ir_out             = r_ir_out;
    assign ir_upd_pulse       = r_ir_upd_pulse;
    assign st_ready_test_idle = w_rti_s;

endmodule

// File: tb/tb_debug_scan_slave.sv
// tb_debug_scan_slave: directed bench with a delay-line behavioural model
// compared every cycle, plus literal checks for the scenarios.
module tb_debug_scan_slave;

    localparam int DRW = 38;
    localparam int IRW = 2;
    localparam int NCH = 3;
    localparam int SS  = 2;
    localparam int H   = SS + 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              tck = 1'b0;
    logic              tdi = 1'b0;
    logic              tdo;
    logic              vs_cdr = 1'b0;
    logic              vs_sdr = 1'b0;
    logic              vs_udr = 1'b0;
    logic              vs_uir = 1'b0;
    logic              jtag_state_rti = 1'b0;
    logic [IRW-1:0]    ir_in = '0;
    logic [IRW-1:0]    ir_out;
    logic [NCH*DRW-1:0] cap_data;
    logic [DRW-1:0]    jdo;
    logic              upd_valid;
    logic [IRW-1:0]    upd_ch;
    logic              upd_ready = 1'b0;
    logic              ir_upd_pulse;
    logic              st_ready_test_idle;
    logic              overrun;
    logic              overrun_clr = 1'b0;

    logic [DRW-1:0] cap_w [NCH];

    int n_tests = 0;
    int n_fail  = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            cap_data[k*DRW +: DRW] = cap_w[k];
        end
    end

    debug_scan_slave #(
        .DR_WIDTH(DRW), .IR_WIDTH(IRW),
        .NUM_CH(NCH), .SYNC_STAGES(SS)
    ) dut (
        .clk(clk), .reset(reset), .tck(tck), .tdi(tdi), .tdo(tdo),
        .vs_cdr(vs_cdr), .vs_sdr(vs_sdr), .vs_udr(vs_udr),
        .vs_uir(vs_uir), .jtag_state_rti(jtag_state_rti),
        .ir_in(ir_in), .ir_out(ir_out), .cap_data(cap_data),
        .jdo(jdo), .upd_valid(upd_valid), .upd_ch(upd_ch),
        .upd_ready(upd_ready), .ir_upd_pulse(ir_upd_pulse),
        .st_ready_test_idle(st_ready_test_idle),
        .overrun(overrun), .overrun_clr(overrun_clr)
    );

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic tck, tdi, cdr, sdr, udr, uir, rti;
        logic [IRW-1:0] ir;
    } jin_t;

    jin_t           h [SS+2];
    logic [DRW-1:0] m_sr = '0;
    logic [DRW-1:0] m_jdo = '0;
    logic           m_valid = 1'b0;
    logic [IRW-1:0] m_ch = '0;
    logic           m_ovr = 1'b0;
    logic [IRW-1:0] m_irout = '0;
    logic           m_pulse = 1'b0;
    logic           m_rti = 1'b0;

    // The design sees the JTAG inputs SS cycles late; h[k] is k cycles old.
    always @(posedge clk) begin : model
        jin_t cur, prv;
        logic acc, drop, ov0, va0;
        acc = 1'b0;
        drop = 1'b0;
        if (reset) begin
            for (int k = 0; k < SS + 2; k++) h[k] = '0;
            m_sr = '0; m_jdo = '0; m_valid = 1'b0; m_ch = '0;
            m_ovr = 1'b0; m_irout = '0; m_pulse = 1'b0; m_rti = 1'b0;
        end else begin
            ov0 = m_ovr;
            va0 = m_valid;
            for (int k = SS + 1; k > 0; k--) h[k] = h[k-1];
            h[0] = '{tck, tdi, vs_cdr, vs_sdr, vs_udr, vs_uir,
                     jtag_state_rti, ir_in};
            cur = h[SS];
            prv = h[SS+1];
            m_rti = h[SS-1].rti;
            m_irout = {ov0, va0};
            m_pulse = 1'b0;
            if (cur.tck && !prv.tck) begin
                if (cur.cdr) begin
                    m_sr = (int'(cur.ir) < NCH) ? cap_w[cur.ir] : '0;
                end else if (cur.sdr) begin
                    m_sr = {cur.tdi, m_sr[DRW-1:1]};
                end else if (cur.udr) begin
                    if (int'(cur.ir) < NCH) begin
                        if (!m_valid || upd_ready) begin
                            m_jdo = m_sr;
                            m_ch = cur.ir;
                            m_valid = 1'b1;
                            acc = 1'b1;
                        end else begin
                            drop = 1'b1;
                        end
                    end
                end else if (cur.uir) begin
                    m_pulse = 1'b1;
                end
            end
            if (!acc && upd_ready) m_valid = 1'b0;
            if (drop) m_ovr = 1'b1;
            else if (overrun_clr) m_ovr = 1'b0;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            n_tests++;
            if (tdo !== m_sr[0] || jdo !== m_jdo ||
                upd_valid !== m_valid || upd_ch !== m_ch ||
                overrun !== m_ovr || ir_out !== m_irout ||
                ir_upd_pulse !== m_pulse ||
                st_ready_test_idle !== m_rti) begin
                n_fail++;
                $display("FAIL model t=%0t got tdo=%b jdo=%h v=%b ch=%0d ov=%b ir=%b p=%b rti=%b want tdo=%b jdo=%h v=%b ch=%0d ov=%b ir=%b p=%b rti=%b",
                    $time, tdo, jdo, upd_valid, upd_ch, overrun, ir_out,
                    ir_upd_pulse, st_ready_test_idle, m_sr[0], m_jdo,
                    m_valid, m_ch, m_ovr, m_irout, m_pulse, m_rti);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic jop(input logic c, s, u, i, d);
        vs_cdr = c; vs_sdr = s; vs_udr = u; vs_uir = i; tdi = d;
        tck = 1'b1;
        cyc(H);
        tck = 1'b0;
        cyc(H);
        vs_cdr = 0; vs_sdr = 0; vs_udr = 0; vs_uir = 0; tdi = 0;
    endtask

    task automatic shift_word(input logic [DRW-1:0] w);
        for (int i = 0; i < DRW; i++) jop(0, 1, 0, 0, w[i]);
    endtask

    // UDR whose action edge has the given ready/clr levels.
    task automatic udr_at(input logic rdy, input logic clr);
        vs_udr = 1'b1;
        tck = 1'b1;
        cyc(SS);
        upd_ready = rdy;
        overrun_clr = clr;
        cyc(1);
        upd_ready = 1'b0;
        overrun_clr = 1'b0;
        cyc(H - SS - 1);
        tck = 1'b0;
        cyc(H);
        vs_udr = 1'b0;
    endtask

    initial begin : stim
        logic [DRW-1:0] got;
        int np;
        cap_w[0] = 38'h0_DEAD_BEEF;
        cap_w[1] = 38'h3F_FFFF_0000;
        cap_w[2] = 38'h2_A5A5_A5A5;
        cyc(1);
        chk_en = 1'b1;
        cyc(2);
        reset = 1'b0;
        check("rst_jdo", 64'(jdo), 64'h0);
        check("rst_valid", 64'(upd_valid), 64'h0);
        check("rst_irout", 64'(ir_out), 64'h0);
        check("rst_tdo", 64'(tdo), 64'h0);
        cyc(2);

        // capture channel 2 then shift out with tdi=0
        ir_in = 2;
        jop(1, 0, 0, 0, 0);
        got = '0;
        for (int i = 0; i < DRW; i++) begin
            got[i] = tdo;
            jop(0, 1, 0, 0, 0);
        end
        check("shift_first8", 64'(got[7:0]), 64'h A5);
        check("shift_word", 64'(got), 64'h2_A5A5_A5A5);
        check("shift_empty", 64'(tdo), 64'h0);

        // update handshake and latency
        ir_in = 1;
        shift_word(38'h15_1234_5678);
        vs_udr = 1'b1;
        tck = 1'b1;
        cyc(SS);
        check("lat_early", 64'(upd_valid), 64'h0);
        cyc(1);
        check("lat_valid", 64'(upd_valid), 64'h1);
        check("upd_jdo", 64'(jdo), 64'h15_1234_5678);
        check("upd_ch", 64'(upd_ch), 64'h1);
        cyc(H - SS - 1);
        tck = 1'b0;
        cyc(H);
        vs_udr = 1'b0;

        // overrun on a second word while one is pending
        shift_word(38'h1);
        jop(0, 0, 1, 0, 0);
        check("ovr_jdo", 64'(jdo), 64'h15_1234_5678);
        check("ovr_set", 64'(overrun), 64'h1);
        check("ovr_irout", 64'(ir_out), 64'h3);
        overrun_clr = 1'b1;
        cyc(1);
        overrun_clr = 1'b0;
        cyc(1);
        check("ovr_clr", 64'(overrun), 64'h0);
        check("ovr_clr_irout", 64'(ir_out), 64'h1);
        udr_at(1'b0, 1'b1);
        check("ovr_set_wins", 64'(overrun), 64'h1);
        overrun_clr = 1'b1;
        cyc(1);
        overrun_clr = 1'b0;
        upd_ready = 1'b1;
        cyc(1);
        upd_ready = 1'b0;
        check("hs_consumed", 64'(upd_valid), 64'h0);
        cyc(2);

        // simultaneous accept of a pending word and a new one
        jop(0, 0, 1, 0, 0);
        check("sim_pre", 64'(jdo), 64'h1);
        shift_word(38'h3F_0F0F_00FF);
        udr_at(1'b1, 1'b0);
        check("sim_valid", 64'(upd_valid), 64'h1);
        check("sim_jdo", 64'(jdo), 64'h3F_0F0F_00FF);
        check("sim_ovr", 64'(overrun), 64'h0);
        upd_ready = 1'b1;
        cyc(1);
        upd_ready = 1'b0;
        cyc(1);

        // out-of-range instruction
        jtag_state_rti = 1'b1;
        ir_in = 3;
        jop(1, 0, 0, 0, 0);
        np = 0;
        for (int i = 0; i < DRW; i++) begin
            if (tdo !== 1'b0) np++;
            jop(0, 1, 0, 0, 0);
        end
        check("oor_tdo_ones", 64'(np), 64'h0);
        jop(0, 0, 1, 0, 0);
        check("oor_valid", 64'(upd_valid), 64'h0);
        check("oor_ovr", 64'(overrun), 64'h0);
        check("rti_on", 64'(st_ready_test_idle), 64'h1);

        // reset mid-shift with a pending word
        ir_in = 1;
        jop(0, 0, 1, 0, 0);
        ir_in = 0;
        jop(1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) jop(0, 1, 0, 0, 1);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        check("mrst_tdo", 64'(tdo), 64'h0);
        check("mrst_valid", 64'(upd_valid), 64'h0);
        check("mrst_jdo", 64'(jdo), 64'h0);
        check("mrst_ch", 64'(upd_ch), 64'h0);
        check("mrst_irout", 64'(ir_out), 64'h0);
        check("mrst_rti", 64'(st_ready_test_idle), 64'h0);
        cyc(H);
        jop(1, 0, 0, 0, 0);
        check("post_cap", 64'(tdo), 64'h1);
        jop(0, 1, 0, 0, 0);
        jop(0, 1, 0, 0, 0);
        check("post_shift", 64'(tdo), 64'h1);
        vs_uir = 1'b1;
        tck = 1'b1;
        np = 0;
        for (int i = 0; i < 2 * H; i++) begin
            if (i == H) tck = 1'b0;
            cyc(1);
            if (ir_upd_pulse === 1'b1) np++;
        end
        vs_uir = 1'b0;
        check("uir_pulse_len", 64'(np), 64'h1);
        cyc(4);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/debug_scan_slave.md
Name: debug_scan_slave

Overview:
- Parametrised successor to the CPU debug-slave front end; the next-generation virtual-JTAG serial endpoint for the debug module.
- Oversamples a virtual-JTAG port (tck, tdi, virtual states) in the system clock domain and shifts through a DR_WIDTH scan register.
- Captures from one of NUM_CH per-channel capture buses, selected by the instruction register.
- Delivers updated words to the system side through a valid/ready handshake, with overrun detection. The previous generation had no such handshake.

Parameters:
- DR_WIDTH, 38: scan/data register width (≥2).
- IR_WIDTH, 2: virtual instruction width (≥2).
- NUM_CH, 4: number of capture/update channels (1..2**IR_WIDTH).
- SYNC_STAGES, 2: synchroniser depth for all JTAG-side inputs (≥2).

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-high reset.
- tck, in, 1: virtual JTAG clock (asynchronous; sampled).
- tdi, in, 1: serial data in.
- tdo, out, 1: serial data out.
- vs_cdr, in, 1: virtual capture-DR state.
- vs_sdr, in, 1: virtual shift-DR state.
- vs_udr, in, 1: virtual update-DR state.
- vs_uir, in, 1: virtual update-IR state.
- jtag_state_rti, in, 1: run-test/idle state.
- ir_in, in, IR_WIDTH: current instruction / channel select.
- ir_out, out, IR_WIDTH: status returned on IR capture.
- cap_data, in, NUM_CH*DR_WIDTH: capture words; channel k occupies bits [k*DR_WIDTH +: DR_WIDTH].
- jdo, out, DR_WIDTH: last accepted update word.
- upd_valid, out, 1: update word pending.
- upd_ch, out, IR_WIDTH: channel of the pending word.
- upd_ready, in, 1: consumer accepts the pending word.
- ir_upd_pulse, out, 1: one-cycle pulse on update-IR.
- st_ready_test_idle, out, 1: registered, synchronised jtag_state_rti.
- overrun, out, 1: sticky flag; an update was dropped.
- overrun_clr, in, 1: clears overrun.

Behaviour:
- Reset values: tdo source register (sr) = 0, jdo = 0, upd_valid = 0, upd_ch = 0, ir_out = 0, ir_upd_pulse = 0, st_ready_test_idle = 0, overrun = 0, all synchroniser flops = 0.
- Reset asserted mid-shift discards the partial sr contents and any pending update.
- Synchronisation:
  - tck, tdi, vs_*, jtag_state_rti and ir_in each pass through SYNC_STAGES flops, so they stay mutually aligned.
  - tck_rise = synchronised tck & ~(its previous registered value).
  - Action latency is SYNC_STAGES+1 clk cycles after the tck rising edge.
  - Operating constraint: tck high and low phases each ≥ SYNC_STAGES+1 clk periods.
- On a tck_rise cycle only, the highest-priority asserted state acts (cdr > sdr > udr > uir):
  - CDR: if ir_s < NUM_CH, sr <= cap_data slice ir_s; otherwise sr <= 0.
  - SDR: sr <= {tdi_s, sr[DR_WIDTH-1:1]} (LSB-first shift).
  - UDR, with ir_s < NUM_CH: if upd_valid==0, or upd_ready==1 in the same cycle, then jdo <= sr, upd_ch <= ir_s, upd_valid <= 1. Otherwise jdo and upd_ch are unchanged and overrun <= 1.
  - UDR, with ir_s ≥ NUM_CH: ignored; no flag is raised.
  - UIR: ir_upd_pulse = 1 for exactly one clk cycle.
- tdo = sr[0], driven directly from the register with no combinational path from inputs.
- Handshake:
  - upd_valid holds until a cycle in which upd_ready = 1.
  - It clears on the next edge unless a new update is accepted in that same cycle, in which case it stays 1 with the new jdo/upd_ch.
  - jdo remains stable while upd_valid = 1.
- ir_out is registered every clk: {zeros, overrun, upd_valid}, with overrun at bit 1 and upd_valid at bit 0.
- overrun_clr clears overrun. If a set condition occurs in the same cycle, set wins.
- st_ready_test_idle is the synchronised jtag_state_rti, with no further delay.
- Outside tck_rise cycles, sr holds its value.

Test Plan:
- Capture/shift: NUM_CH=4, DR_WIDTH=38, cap_data ch2 = 38'h2_A5A5_A5A5, ir_in=2, CDR then 38 SDR tck pulses with tdi=0 → tdo sequence = 1,0,1,0,0,1,0,1,… (LSB first); final sr = 0.
- Update handshake: shift in 38'h15_1234_5678, ir_in=1, UDR pulse, upd_ready=0 → upd_valid=1 and jdo=38'h15_1234_5678, upd_ch=1 exactly SYNC_STAGES+1 cycles after the tck edge; raise upd_ready for 1 cycle → upd_valid=0 on the next cycle.
- Overrun: second UDR (data 38'h1) while upd_valid=1 and upd_ready=0 → jdo unchanged, overrun=1, ir_out=2'b11; overrun_clr pulse → overrun=0, ir_out=2'b01; overrun_clr asserted in the same cycle as a new drop → overrun stays 1.
- Out-of-range channel: NUM_CH=3, ir_in=3, CDR → sr=0 (tdo 0 for all 38 shifts); UDR → upd_valid stays 0, overrun stays 0.
- Simultaneous accept: upd_valid=1, upd_ready=1 in the same cycle as a new UDR action → upd_valid stays 1, jdo = new word, overrun=0.
- Reset mid-shift: assert reset after 10 SDR shifts → all outputs at reset values next cycle; subsequent CDR/SDR operate normally; UIR → ir_upd_pulse high exactly 1 cycle.
